// File: rtl/alu_seq_pkg.sv
// Shared encodings and pass counts for the time-shared nibble ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned RES_W = 8;

  typedef enum logic [1:0] {
    OP_INC = 2'd0,
    OP_ADD = 2'd1,
    OP_MUL = 2'd2,
    OP_ACC = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned PASSES_INC = 1;
  localparam int unsigned PASSES_ADD = 1;
  localparam int unsigned PASSES_ACC = 2;
  localparam int unsigned PASSES_MUL = 4;

  // Step value on which the final adder pass of an op happens.
  function automatic logic [1:0] last_step(input op_t o);
    case (o)
      OP_INC:  last_step = 2'(PASSES_INC - 1);
      OP_ADD:  last_step = 2'(PASSES_ADD - 1);
      OP_ACC:  last_step = 2'(PASSES_ACC - 1);
      default: last_step = 2'(PASSES_MUL - 1);
    endcase
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// 4-bit ripple-carry adder built from four full-adder bit cells.
module nibble_adder
  import alu_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[NIB_W];

endmodule

// File: rtl/alu_sequencer.sv
// Start/busy/done controller sharing one nibble adder across INC, ADD, MUL and 8-bit ACC.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             ovf
);

  state_t           state, state_nxt;
  op_t              op_q;
  logic [NIB_W-1:0] a_q, b_q;
  logic [1:0]       step;
  logic [RES_W-1:0] p;
  logic             c;
  logic [NIB_W-1:0] x, y, sum;
  logic             cin, cout;
  logic             last;

  nibble_adder u_adder (
    .a    (x),
    .b    (y),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  assign last = (step == last_step(op_q));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    x   = a_q;
    y   = '0;
    cin = 1'b0;
    case (op_q)
      OP_INC: y = NIB_W'(1);
      OP_ADD: y = b_q;
      OP_ACC: begin
        if (step == 2'd0) begin
          x = result[NIB_W-1:0];
          y = b_q;
        end else begin
          x   = result[RES_W-1:NIB_W];
          y   = a_q;
          cin = c;
        end
      end
      default: begin
        x = p[RES_W-1:NIB_W];
        y = p[0] ? a_q : '0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // MUL keeps its partial product in p so result only moves on the final pass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q   <= OP_INC;
      a_q    <= '0;
      b_q    <= '0;
      step   <= '0;
      p      <= '0;
      c      <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        op_q <= op_t'(op);
        a_q  <= a;
        b_q  <= b;
        step <= '0;
        p    <= {{NIB_W{1'b0}}, b};
      end
    end else if (state == RUN) begin
      step <= step + 2'd1;
      case (op_q)
        OP_INC, OP_ADD: begin
          result <= {3'b000, cout, sum};
          ovf    <= 1'b0;
        end
        OP_ACC: begin
          if (step == 2'd0) begin
            result[NIB_W-1:0] <= sum;
            c                 <= cout;
          end else begin
            result[RES_W-1:NIB_W] <= sum;
            ovf                   <= cout;
          end
        end
        default: begin
          p <= {cout, sum, p[NIB_W-1:1]};
          if (last) begin
            result <= {cout, sum, p[NIB_W-1:1]};
            ovf    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table, scoreboard queue, multi-cycle corner sequences.
module tb_alu_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op    = 2'd0;
  logic [3:0] a     = 4'h0;
  logic [3:0] b     = 4'h0;
  logic       busy, done, ovf;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] r;
    logic       o;
    int         lat;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    bit         rst_before;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] r;
    logic       o;
    int         lat;
  } vec_t;

  alu_sequencer dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv,
                       input logic [7:0] er, input logic eo, input int lat);
    exp_t e;
    @(negedge clock);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clock);
    #1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    e.r = er;
    e.o = eo;
    e.lat = lat;
    sbq.push_back(e);
  endtask

  // Waits for done; optionally keeps start high and scrambles op/a/b while busy.
  task automatic wait_done(input bit scramble);
    exp_t e;
    int   n;
    bit   got;
    n   = 0;
    got = 1'b0;
    if (!scramble) start = 1'b0;
    while (n < 20 && !got) begin
      if (scramble) begin
        op = 2'($urandom);
        a  = 4'($urandom);
        b  = 4'($urandom);
      end
      @(posedge clock);
      n++;
      #1;
      if (done) got = 1'b1;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (sbq.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk("latency", n, e.lat);
      chk("result", {24'd0, result}, {24'd0, e.r});
      chk("ovf", {31'd0, ovf}, {31'd0, e.o});
    end
    @(posedge clock);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 2'd0, 4'hF, 4'h0, 8'h10, 1'b0, 1};
    vecs[1] = '{1'b0, 2'd1, 4'h9, 4'h8, 8'h11, 1'b0, 1};
    vecs[2] = '{1'b0, 2'd1, 4'h0, 4'h0, 8'h00, 1'b0, 1};
    vecs[3] = '{1'b0, 2'd2, 4'hF, 4'hF, 8'hE1, 1'b0, 4};
    vecs[4] = '{1'b0, 2'd2, 4'h0, 4'h7, 8'h00, 1'b0, 4};
    vecs[5] = '{1'b0, 2'd2, 4'h3, 4'h5, 8'h0F, 1'b0, 4};
    vecs[6] = '{1'b1, 2'd3, 4'hF, 4'hF, 8'hFF, 1'b0, 2};
    vecs[7] = '{1'b0, 2'd3, 4'h0, 4'h1, 8'h00, 1'b1, 2};
    vecs[8] = '{1'b0, 2'd1, 4'h1, 4'h1, 8'h02, 1'b0, 1};

    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", {24'd0, result}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("idle_no_start", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst_before) begin
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("result_cleared", {24'd0, result}, 32'd0);
      end
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].o, vecs[i].lat);
      wait_done(1'b0);
    end

    // MUL with start held and inputs scrambled while busy.
    issue(2'd2, 4'h2, 4'h3, 8'h06, 1'b0, 4);
    wait_done(1'b1);
    // start was high through DONE and its exit edge; the next op lands one edge later.
    issue(2'd1, 4'h1, 4'h1, 8'h02, 1'b0, 1);
    wait_done(1'b0);

    // Asynchronous reset between edges k+2 and k+3 of a MUL.
    issue(2'd2, 4'hF, 4'hF, 8'hE1, 1'b0, 4);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3;
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    chk("result_before_abort", {24'd0, result}, 32'h02);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {24'd0, result}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    void'(sbq.pop_back());
    @(negedge clock);
    reset = 1'b0;
    issue(2'd1, 4'h5, 4'h5, 8'h0A, 1'b0, 1);
    wait_done(1'b0);

    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
